// File: rtl/image_stream_controller.sv
// image_stream_controller
// Captures one image from an upstream pixel source into a local buffer,
// replays it to the regnet core as LANES-wide beats framed by image_ready,
// then waits for regnet's label strobe (or a timeout) and hands the outcome
// to a downstream consumer over a valid/ready result port.
//
// Ports
//   clock, reset       system clock, synchronous active-high reset
//   flush              synchronous abort back to LOAD (buffer kept)
//   pixel_in/valid     upstream pixel stream; pixel_ready while loading
//   image_ready/pixels regnet stream frame and current beat
//   label/label_ready  regnet argmax result and its strobe
//   result_*           captured label / timeout flag, valid/ready handshake
//   busy               anything other than an idle, empty LOAD
module image_stream_controller #(
    parameter  int unsigned INTEGER_WIDTH  = 16,
    parameter  int unsigned FRACTION_WIDTH = 16,
    parameter  int unsigned NUM_PIXELS     = 10,
    parameter  int unsigned LANES          = 1,
    parameter  int unsigned NUM_CLASSES    = 10,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned PW             = INTEGER_WIDTH + FRACTION_WIDTH,
    localparam int unsigned LW             = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic signed [PW-1:0] pixel_in,
    input  logic                 pixel_valid,
    output logic                 pixel_ready,
    output logic                 image_ready,
    output logic signed [PW-1:0] pixels [LANES],
    input  logic        [LW-1:0] label,
    input  logic                 label_ready,
    output logic        [LW-1:0] result_label,
    output logic                 result_timeout,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy
);

    localparam int unsigned NB  = (NUM_PIXELS + LANES - 1) / LANES;
    localparam int unsigned PCW = $clog2(NUM_PIXELS + 1);
    localparam int unsigned BCW = $clog2(NB + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_STREAM = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    logic        [PCW-1:0] r_pcnt;
    logic        [BCW-1:0] r_bcnt;
    logic        [TCW-1:0] r_tcnt;
    logic signed [PW-1:0]  r_buf [NUM_PIXELS];
    logic                  r_image_ready;
    logic signed [PW-1:0]  r_pixels [LANES];
    logic        [LW-1:0]  r_result_label;
    logic                  r_result_timeout;
    logic                  r_result_valid;

    logic                  w_accept;
    logic                  w_last;
    logic        [BCW-1:0] w_beat_sel;
    logic signed [PW-1:0]  w_beat [LANES];

    assign w_accept   = (r_state == S_LOAD) && pixel_valid;
    assign w_last     = w_accept && (r_pcnt == PCW'(NUM_PIXELS - 1));
    // While loading, the only beat we ever need next is beat 0.
    assign w_beat_sel = (r_state == S_LOAD) ? '0 : r_bcnt;

    // Beat assembly with zero padding; the pixel being written on the final
    // accept is forwarded so a single-beat image is complete on entry.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            int unsigned idx;
            idx       = 32'(w_beat_sel) * LANES + i;
            w_beat[i] = '0;
            if (idx < NUM_PIXELS) begin
                if ((r_state == S_LOAD) && (idx == NUM_PIXELS - 1))
                    w_beat[i] = pixel_in;
                else
                    w_beat[i] = r_buf[AW'(idx)];
            end
        end
    end

    // Image buffer: cleared by reset only, a flush leaves it intact.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PIXELS; i++)
                r_buf[i] <= '0;
        end else if (!flush && w_accept) begin
            r_buf[AW'(r_pcnt)] <= pixel_in;
        end
    end

    // Control FSM with registered stream/result outputs.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_state          <= S_LOAD;
            r_pcnt           <= '0;
            r_bcnt           <= '0;
            r_tcnt           <= '0;
            r_image_ready    <= 1'b0;
            r_result_label   <= '0;
            r_result_timeout <= 1'b0;
            r_result_valid   <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++)
                r_pixels[i] <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_last) begin
                        r_pcnt        <= '0;
                        r_bcnt        <= BCW'(1);
                        r_image_ready <= 1'b1;
                        r_pixels      <= w_beat;
                        r_state       <= S_STREAM;
                    end else if (w_accept) begin
                        r_pcnt <= r_pcnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    // r_bcnt is the index of the beat to present next.
                    if (r_bcnt == BCW'(NB)) begin
                        r_image_ready <= 1'b0;
                        r_bcnt        <= '0;
                        r_tcnt        <= '0;
                        r_state       <= S_WAIT;
                        for (int unsigned i = 0; i < LANES; i++)
                            r_pixels[i] <= '0;
                    end else begin
                        r_pixels <= w_beat;
                        r_bcnt   <= r_bcnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A label on the final cycle beats the timeout.
                    if (label_ready) begin
                        r_result_label   <= label;
                        r_result_timeout <= 1'b0;
                        r_result_valid   <= 1'b1;
                        r_tcnt           <= '0;
                        r_state          <= S_DONE;
                    end else if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                        r_result_label   <= '0;
                        r_result_timeout <= 1'b1;
                        r_result_valid   <= 1'b1;
                        r_tcnt           <= '0;
                        r_state          <= S_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_state        <= S_LOAD;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign pixel_ready    = (r_state == S_LOAD);
    assign busy           = (r_state != S_LOAD) || (r_pcnt != '0);
    assign image_ready    = r_image_ready;
    assign pixels         = r_pixels;
    assign result_label   = r_result_label;
    assign result_timeout = r_result_timeout;
    assign result_valid   = r_result_valid;

endmodule

// File: doc/image_stream_controller.md
Name: image_stream_controller

Overview:
- Hardware replacement for testbench-driven image feeding of the regnet inference core.
- Accepts one image from an upstream pixel source, one pixel per handshake, into an internal buffer.
- Streams the buffered image to regnet in LANES-wide beats with image_ready framing, then waits for label_ready.
- Returns the captured label, or a timeout flag, through a valid/ready result port.

Parameters:
- INTEGER_WIDTH, 16: integer bits of signed fixed-point pixel.
- FRACTION_WIDTH, 16: fraction bits of signed fixed-point pixel.
- NUM_PIXELS, 10: pixels per image, ≥1.
- LANES, 1: pixels per streamed beat (regnet INPUT_SIZE), ≥1.
- NUM_CLASSES, 10: output layer size; label width LW = $clog2(NUM_CLASSES), min 1.
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before abort, ≥1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  synchronous abort to LOAD; buffer contents are kept but invalidated.
- pixel_in  in  INTEGER_WIDTH+FRACTION_WIDTH (signed)  upstream pixel.
- pixel_valid  in  1  pixel_in valid.
- pixel_ready  out  1  controller accepts pixel this cycle.
- image_ready  out  1  regnet stream frame; high for exactly NB = ceil(NUM_PIXELS/LANES) consecutive cycles.
- pixels  out  LANES x (INTEGER_WIDTH+FRACTION_WIDTH) (signed, unpacked)  current beat.
- label  in  LW  regnet argmax output.
- label_ready  in  1  regnet result strobe.
- result_label  out  LW  captured label.
- result_timeout  out  1  result caused by timeout; result_label is 0 in that case.
- result_valid  out  1  result held.
- result_ready  in  1  downstream consumes result.
- busy  out  1  state != LOAD or pixel count != 0.

Behaviour:
- Reset: state LOAD; pixel count, beat count and timeout count 0. Outputs: pixel_ready 1 (combinational from state LOAD), image_ready 0, pixels all 0, result_valid 0, result_label 0, result_timeout 0, busy 0.
- LOAD:
  - pixel_ready = 1.
  - On pixel_valid: write buffer[count] and increment count.
  - Acceptance of pixel NUM_PIXELS-1: next state STREAM, count cleared.
- STREAM (registered outputs):
  - Entry cycle drives image_ready=1 and beat 0.
  - Beat b: pixels[i] = buffer[b*LANES+i] when that index < NUM_PIXELS, else 0 (zero-pad final partial beat).
  - One beat per cycle, no stalls.
  - After beat NB-1: image_ready=0, pixels cleared to 0, state WAIT.
  - Latency: first beat appears on the cycle after the last pixel is accepted.
- WAIT:
  - Timeout counter increments each cycle.
  - label_ready=1: capture label into result_label, result_timeout=0, result_valid=1, state DONE.
  - Counter reaching TIMEOUT_CYCLES-1 without label_ready: result_label=0, result_timeout=1, result_valid=1, state DONE.
  - label_ready on that same final cycle: label wins, no timeout.
- DONE:
  - Result held stable while result_valid && !result_ready.
  - On result_ready: result_valid=0, state LOAD, counters 0.
- Ignored inputs:
  - label_ready outside WAIT is ignored.
  - pixel_valid outside LOAD is ignored; pixel_ready=0 there.
- flush: any state → LOAD next cycle. Clears image_ready, pixels, result_valid, result_timeout and all counters. Equivalent to reset except the buffer RAM is not cleared. reset has priority over flush.
- Mid-image in LOAD: flush discards partial pixel count.
- Arithmetic:
  - Pixel count width $clog2(NUM_PIXELS+1).
  - Beat count width $clog2(NB+1).
  - Timeout count width $clog2(TIMEOUT_CYCLES+1).
  - No wrap possible.

Test Plan:
- NUM_PIXELS=10, LANES=1: load pixels i.0 for i=0..9 with continuous valid → image_ready high 10 cycles, pixels[0]=0.0,1.0,…,9.0. Assert label=7 with label_ready 3 cycles later → result_valid, result_label=7, result_timeout=0.
- LANES=4, same image → 3 beats {0,1,2,3},{4,5,6,7},{8,9,0,0}; image_ready exactly 3 cycles.
- Gapped pixel_valid (every other cycle), plus pixel_valid held during STREAM/WAIT → only 10 writes, pixel_ready=0 outside LOAD, stream contents unchanged.
- TIMEOUT_CYCLES=8, never assert label_ready → result_valid after 8 WAIT cycles, result_timeout=1, result_label=0.
- Result backpressure: result_ready low 5 cycles → result_label stable, no new pixel accepted. result_ready=1 → LOAD next cycle, second image processes correctly.
- flush at beat 2 of STREAM (LANES=1) → image_ready 0 next cycle, state LOAD, busy 0. Reset pulse mid-WAIT → all outputs at reset values; late label_ready ignored.
